// File: rtl/fwd_hazard_unit.sv
// Operand/flag forwarding plus load-use hazard detection for a 5-stage pipeline.
// Forwarding paths are purely combinational; the stall sequencer is a small IDLE/STALL FSM.
module fwd_hazard_unit #(
    parameter int DATA_W   = 64,
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  Aa,
    input  logic [REG_W-1:0]  Ab,
    input  logic [DATA_W-1:0] Da_rf,
    input  logic [DATA_W-1:0] Db_rf,
    input  logic [REG_W-1:0]  rd_ex,
    input  logic [REG_W-1:0]  rd_mem,
    input  logic [REG_W-1:0]  rd_wb,
    input  logic              regwrite_ex,
    input  logic              regwrite_mem,
    input  logic              regwrite_wb,
    input  logic              memread_ex,
    input  logic [DATA_W-1:0] d_ex,
    input  logic [DATA_W-1:0] d_mem,
    input  logic [DATA_W-1:0] d_wb,
    input  logic [3:0]        flags_ex,
    input  logic              FlagUp_ex,
    output logic [DATA_W-1:0] Da,
    output logic [DATA_W-1:0] Db,
    output logic [3:0]        flags,
    output logic              stall,
    output logic              bubble,
    output logic [31:0]       stall_cycles
);

    localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       flags_q;
    logic [31:0]      stall_cycles_q, stall_cycles_d;

    logic ex_safe, mem_safe, wb_safe;
    logic hazard;
    logic stall_int;

    logic [REG_W-1:0]  src_idx  [2];
    logic [DATA_W-1:0] rf_data  [2];
    logic [DATA_W-1:0] fwd_data [2];

    // A stage writing the hard-zero register never supplies data nor causes a hazard.
    assign ex_safe  = regwrite_ex  && (rd_ex  != ZERO_IDX);
    assign mem_safe = regwrite_mem && (rd_mem != ZERO_IDX);
    assign wb_safe  = regwrite_wb  && (rd_wb  != ZERO_IDX);

    assign src_idx[0] = Aa;
    assign src_idx[1] = Ab;
    assign rf_data[0] = Da_rf;
    assign rf_data[1] = Db_rf;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            // Youngest producer wins: EX, then MEM, then WB, then the register file.
            always_comb begin
                fwd_data[gi] = rf_data[gi];
                if (src_idx[gi] != ZERO_IDX) begin
                    if (ex_safe && (rd_ex == src_idx[gi])) begin
                        fwd_data[gi] = d_ex;
                    end else if (mem_safe && (rd_mem == src_idx[gi])) begin
                        fwd_data[gi] = d_mem;
                    end else if (wb_safe && (rd_wb == src_idx[gi])) begin
                        fwd_data[gi] = d_wb;
                    end
                end
            end
        end
    endgenerate

    assign Da = fwd_data[0];
    assign Db = fwd_data[1];

    assign flags = FlagUp_ex ? flags_ex : flags_q;

    assign hazard = id_valid && memread_ex && ex_safe &&
                    ((rd_ex == Aa) || (rd_ex == Ab));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_int = 1'b0;
        case (state_q)
            IDLE: begin
                stall_int = hazard;
                // With a one-cycle latency the IDLE cycle itself is the whole stall.
                if (hazard && (LOAD_LAT > 1)) begin
                    state_d = STALL;
                    cnt_d   = CNT_INIT;
                end
            end
            STALL: begin
                stall_int = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign stall  = stall_int;
    assign bubble = stall_int;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_int && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            flags_q        <= 4'b0000;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
            if (FlagUp_ex) begin
                flags_q <= flags_ex;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: one instance with a one-cycle load-use stall and one with three cycles,
// sharing all inputs.
module tb_fwd_hazard_unit;

    localparam int DW = 64;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [RW-1:0] Aa, Ab, rd_ex, rd_mem, rd_wb;
    logic [DW-1:0] Da_rf, Db_rf, d_ex, d_mem, d_wb;
    logic          regwrite_ex, regwrite_mem, regwrite_wb, memread_ex;
    logic [3:0]    flags_ex;
    logic          FlagUp_ex;

    logic [DW-1:0] u1_da, u1_db, u3_da, u3_db;
    logic [3:0]    u1_flags, u3_flags;
    logic          u1_stall, u1_bubble, u3_stall, u3_bubble;
    logic [31:0]   u1_cnt, u3_cnt;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.DATA_W(DW), .REG_W(RW), .ZERO_REG(31), .LOAD_LAT(1)) u1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .Aa(Aa), .Ab(Ab),
        .Da_rf(Da_rf), .Db_rf(Db_rf), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .regwrite_ex(regwrite_ex), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
        .memread_ex(memread_ex), .d_ex(d_ex), .d_mem(d_mem), .d_wb(d_wb),
        .flags_ex(flags_ex), .FlagUp_ex(FlagUp_ex),
        .Da(u1_da), .Db(u1_db), .flags(u1_flags), .stall(u1_stall), .bubble(u1_bubble),
        .stall_cycles(u1_cnt)
    );

    fwd_hazard_unit #(.DATA_W(DW), .REG_W(RW), .ZERO_REG(31), .LOAD_LAT(3)) u3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .Aa(Aa), .Ab(Ab),
        .Da_rf(Da_rf), .Db_rf(Db_rf), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .regwrite_ex(regwrite_ex), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
        .memread_ex(memread_ex), .d_ex(d_ex), .d_mem(d_mem), .d_wb(d_wb),
        .flags_ex(flags_ex), .FlagUp_ex(FlagUp_ex),
        .Da(u3_da), .Db(u3_db), .flags(u3_flags), .stall(u3_stall), .bubble(u3_bubble),
        .stall_cycles(u3_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-18s observed %h expected %h", tag, obs, exp);
    endtask

    // Inputs change one time unit after the rising edge; checks follow one unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; id_valid = 1'b0; Aa = '0; Ab = '0; rd_ex = '0; rd_mem = '0; rd_wb = '0;
        Da_rf = 64'hAAAA; Db_rf = 64'hBBBB; d_ex = '0; d_mem = '0; d_wb = '0;
        regwrite_ex = 1'b0; regwrite_mem = 1'b0; regwrite_wb = 1'b0; memread_ex = 1'b0;
        flags_ex = 4'b0000; FlagUp_ex = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_u1_stall", 64'(u1_stall), 64'd0);
        check("rst_u3_stall", 64'(u3_stall), 64'd0);
        check("rst_u1_cnt", 64'(u1_cnt), 64'd0);
        check("rst_u3_cnt", 64'(u3_cnt), 64'd0);
        check("rst_flags", 64'(u1_flags), 64'd0);

        // Triple-match priority
        id_valid = 1'b1; Aa = 5'd3; Ab = 5'd9;
        rd_ex = 5'd3; rd_mem = 5'd3; rd_wb = 5'd3;
        regwrite_ex = 1'b1; regwrite_mem = 1'b1; regwrite_wb = 1'b1;
        d_ex = 64'd1; d_mem = 64'd2; d_wb = 64'd4;
        #1;
        check("prio_ex", u1_da, 64'd1);
        check("prio_db_rf", u1_db, 64'hBBBB);
        regwrite_ex = 1'b0; #1;
        check("prio_mem", u1_da, 64'd2);
        regwrite_mem = 1'b0; #1;
        check("prio_wb", u1_da, 64'd4);
        regwrite_wb = 1'b0; #1;
        check("prio_rf", u1_da, 64'hAAAA);
        regwrite_ex = 1'b1; regwrite_mem = 1'b1; regwrite_wb = 1'b1;
        Aa = 5'd5; Ab = 5'd3; rd_ex = 5'd8; #1;
        check("prio_db_mem", u3_db, 64'd2);
        check("prio_da_rf", u3_da, 64'hAAAA);
        check("no_load_stall", 64'(u1_stall), 64'd0);

        // Hard-zero register
        Aa = 5'd31; Ab = 5'd1; rd_ex = 5'd31; rd_mem = 5'd31; rd_wb = 5'd31;
        memread_ex = 1'b1; d_ex = 64'h55; Da_rf = 64'd0;
        #1;
        check("zero_da", u1_da, 64'd0);
        check("zero_u1_stall", 64'(u1_stall), 64'd0);
        check("zero_u3_stall", 64'(u3_stall), 64'd0);
        // id_valid gates detection
        rd_ex = 5'd1; id_valid = 1'b0; #1;
        check("novalid_stall", 64'(u1_stall), 64'd0);
        tick();

        // Load-use at LOAD_LAT=1 and 3
        id_valid = 1'b1; regwrite_mem = 1'b0; regwrite_wb = 1'b0;
        Aa = 5'd0; Ab = 5'd7; rd_ex = 5'd7; memread_ex = 1'b1; d_ex = 64'h77;
        #1;
        check("lu_u1_stall0", 64'(u1_stall), 64'd1);
        check("lu_u1_bubble0", 64'(u1_bubble), 64'd1);
        check("lu_u3_stall0", 64'(u3_stall), 64'd1);
        check("lu_db_fwd", u1_db, 64'h77);
        tick();
        memread_ex = 1'b0; #1;
        check("lu_u1_stall1", 64'(u1_stall), 64'd0);
        check("lu_u1_cnt", 64'(u1_cnt), 64'd1);
        check("lu_u3_stall1", 64'(u3_stall), 64'd1);
        check("lu_u3_bubble1", 64'(u3_bubble), 64'd1);
        tick(); #1;
        check("lu_u3_stall2", 64'(u3_stall), 64'd1);
        check("lu_u3_cnt2", 64'(u3_cnt), 64'd2);
        tick(); #1;
        check("lu_u3_stall3", 64'(u3_stall), 64'd0);
        check("lu_u3_cnt3", 64'(u3_cnt), 64'd3);
        check("lu_u1_cnt_hold", 64'(u1_cnt), 64'd1);

        // Back-to-back sequences with the hazard held
        memread_ex = 1'b1; #1;
        check("b2b_a", 64'(u3_stall), 64'd1);
        tick(); #1;
        check("b2b_b", 64'(u3_stall), 64'd1);
        tick(); #1;
        check("b2b_c", 64'(u3_stall), 64'd1);
        tick(); #1;
        check("b2b_restart", 64'(u3_stall), 64'd1);
        check("b2b_u3_cnt", 64'(u3_cnt), 64'd6);
        check("b2b_u1_cnt", 64'(u1_cnt), 64'd4);

        // Reset in the second stall cycle
        memread_ex = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; memread_ex = 1'b1; #1;
        check("rs_stall0", 64'(u3_stall), 64'd1);
        tick();
        memread_ex = 1'b0; reset = 1'b1; #1;
        check("rs_stall1", 64'(u3_stall), 64'd1);
        tick();
        reset = 1'b0; #1;
        check("rs_stall_after", 64'(u3_stall), 64'd0);
        check("rs_cnt_after", 64'(u3_cnt), 64'd0);

        // Flags bypass, hold, and reset priority
        FlagUp_ex = 1'b1; flags_ex = 4'b1010; #1;
        check("flags_bypass", 64'(u1_flags), 64'hA);
        tick();
        FlagUp_ex = 1'b0; flags_ex = 4'b0101; #1;
        check("flags_held", 64'(u1_flags), 64'hA);
        reset = 1'b1; FlagUp_ex = 1'b1; flags_ex = 4'b1111; #1;
        check("flags_bypass_rst", 64'(u1_flags), 64'hF);
        tick();
        reset = 1'b0; FlagUp_ex = 1'b0; #1;
        check("flags_rst", 64'(u1_flags), 64'h0);

        // Saturation of the stall-cycle counter
        force u1.stall_cycles_q = 32'hFFFF_FFFE;
        #1;
        release u1.stall_cycles_q;
        #1;
        check("sat_preload", 64'(u1_cnt), 64'hFFFF_FFFE);
        memread_ex = 1'b1;
        tick(); #1;
        check("sat_first", 64'(u1_cnt), 64'hFFFF_FFFF);
        tick(); tick(); #1;
        check("sat_hold", 64'(u1_cnt), 64'hFFFF_FFFF);
        memread_ex = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning the operand/result width.
REQ-002 SHALL have parameter REG_W, default 5, meaning the register-index width.
REQ-003 SHALL have parameter ZERO_REG, default 31, meaning the hard-zero register index; it is never forwarded and never triggers a hazard.
REQ-004 SHALL have parameter LOAD_LAT, default 1, legal 1..4, meaning the load-use stall length in cycles.
REQ-005 SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  a real instruction is in ID
- Aa, Ab  in  REG_W  ID source indices
- Da_rf, Db_rf  in  DATA_W  register-file read data
- rd_ex, rd_mem, rd_wb  in  REG_W  destination index per stage
- regwrite_ex, regwrite_mem, regwrite_wb  in  1  stage writes its rd
- memread_ex  in  1  EX instruction is a load
- d_ex, d_mem, d_wb  in  DATA_W  stage result data
- flags_ex  in  4  NZCV produced in EX
- FlagUp_ex  in  1  EX instruction sets flags
- Da, Db  out  DATA_W  forwarded operands
- flags  out  4  forwarded NZCV
- stall  out  1  freeze PC and IF/ID
- bubble  out  1  insert NOP into ID/EX
- stall_cycles  out  32  saturating stall-cycle count

Function
REQ-006 SHALL define a stage as "safe" when its regwrite is 1 and its rd != ZERO_REG.
REQ-007 SHALL select each of Da and Db combinationally using the priority EX > MEM > WB > register file; a stage wins only when it is safe and its rd equals the source index.
REQ-008 SHALL output Da_rf/Db_rf unchanged when Aa/Ab equals ZERO_REG, regardless of any stage rd.
REQ-009 SHALL hold a 4-bit flags_q register, loaded with flags_ex on every clock where FlagUp_ex=1 and reset=0.
REQ-010 SHALL drive flags = flags_ex when FlagUp_ex=1, else flags_q, with no cycle of latency.
REQ-011 SHALL raise hazard combinationally when all of the following hold: id_valid=1, memread_ex=1, EX is safe, and rd_ex equals Aa or Ab.
REQ-012 SHALL implement a two-state FSM, IDLE and STALL, with a stall counter cnt sized to hold LOAD_LAT-1.
REQ-013 SHALL drive stall = bubble = hazard while in IDLE.
REQ-014 SHALL, in IDLE with hazard=1 and LOAD_LAT>1, move to STALL and load cnt = LOAD_LAT-2.
REQ-015 SHALL, in IDLE with hazard=1 and LOAD_LAT=1, remain in IDLE, giving exactly one stall cycle.
REQ-016 SHALL drive stall = bubble = 1 while in STALL, ignoring hazard.
REQ-017 SHALL, in STALL, decrement cnt when cnt != 0 and return to IDLE when cnt = 0.
REQ-018 SHALL produce exactly LOAD_LAT consecutive stall cycles per detected hazard.
REQ-019 SHALL allow a hazard detected on the first IDLE cycle after a stall sequence to start a new sequence immediately, with no gap.
REQ-020 SHALL increment stall_cycles by 1 on each clock where stall=1, saturating at 32'hFFFF_FFFF with no wrap.
REQ-021 SHALL compute Da, Db and flags independently of stall; during stall their values are don't-care to the pipeline but must still follow REQ-007..010.

Reset
REQ-022 SHALL, on a clock where reset=1, set FSM = IDLE, cnt = 0, flags_q = 4'b0000 and stall_cycles = 0.
REQ-023 SHALL give reset priority over any hazard or FlagUp_ex on the same clock.
REQ-024 SHALL, when reset is asserted during STALL, deassert stall on the cycle after the reset edge unless a fresh hazard is present.

Verification
REQ-025 SHALL cover triple-match priority: Aa=3, rd_ex=rd_mem=rd_wb=3, all regwrite=1, d_ex=1, d_mem=2, d_wb=4 -> Da=1; with regwrite_ex=0 -> Da=2; with regwrite_mem=0 as well -> Da=4.
REQ-026 SHALL cover the zero register: Aa=31, rd_ex=31, regwrite_ex=1, Da_rf=0 -> Da=0, hazard=0 even with memread_ex=1.
REQ-027 SHALL cover load-use at LOAD_LAT=1: memread_ex=1, rd_ex=Ab=7, id_valid=1 -> stall=bubble=1 for exactly 1 cycle, then 0; stall_cycles=1.
REQ-028 SHALL cover load-use at LOAD_LAT=3 with the same stimulus -> stall=1 for exactly 3 cycles; reset asserted in the 2nd cycle -> stall=0 next cycle and stall_cycles=0.
REQ-029 SHALL cover flags: FlagUp_ex=1, flags_ex=4'b1010 -> flags=4'b1010 same cycle; next cycle FlagUp_ex=0 -> flags=4'b1010 from flags_q; after reset -> flags=4'b0000.
REQ-030 SHALL cover saturation: force stall_cycles to 32'hFFFF_FFFE, then 3 stall cycles -> count ends at 32'hFFFF_FFFF.
